// File: rtl/cp0_timer_intc_pkg.sv
// Shared constants for the CP0 timer / interrupt-pending block.
// Register numbers, Cause bit positions and parameter limits.
package cp0_timer_intc_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;

    // hw_ip index that carries IP7 (shared with the timer)
    localparam int IP7_BIT      = 5;
    localparam int IP6_IP2_BITS = 5;
    localparam int TI_BIT       = 30;

    localparam int COUNT_DIV_MAX   = 16;
    localparam int N_TIMER_MAX     = 4;
    localparam int N_EXT_MAX       = 6;
    localparam int SYNC_STAGES_MAX = 3;
    localparam int PRE_W           = 4;

    function automatic logic reg_hit(
        input logic       wen,
        input logic [4:0] addr,
        input logic [4:0] reg_no
    );
        return wen && (addr == reg_no);
    endfunction

endpackage

// File: rtl/cp0_timer_intc_if.sv
// mtc0 write port and combinational read-back path into the timer block.
// The CP0 register block is the master.
interface cp0_timer_intc_if;
    logic        wen;
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wen, addr, sel, wdata,
        input  rdata
    );

    modport slave (
        input  wen, addr, sel, wdata,
        output rdata
    );
endinterface

// File: rtl/cp0_timer_intc_int_sync.sv
// Asynchronous-input synchroniser: STAGES flops, async-reset to 0.
module int_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= STAGES'({chain, d});
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer with prescaler, external-line synchronisers
// and registered interrupt request to the exception logic.
module cp0_timer_intc
    import cp0_timer_intc_pkg::*;
#(
    parameter int COUNT_DIV   = 2,
    parameter int N_TIMER     = 1,
    parameter int N_EXT       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EXT-1:0] ext_int,
    cp0_timer_intc_if.slave  bus,
    input  logic             status_ie,
    input  logic             status_exl,
    input  logic [7:0]       status_im,
    input  logic [1:0]       sw_ip,
    output logic [5:0]       hw_ip,
    output logic             ti,
    output logic [31:0]      count,
    output logic             int_req
);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             cnt_wr;

    assign tick   = (pre == PRE_LAST);
    assign cnt_wr = reg_hit(bus.wen, bus.addr, CP0_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre   <= '0;
            count <= '0;
        end else if (cnt_wr) begin
            pre   <= '0;
            count <= bus.wdata;
        end else begin
            pre   <= tick ? '0 : pre + 1'b1;
            count <= count + 32'(tick);
        end
    end

    logic [31:0]        cmp_val [N_TIMER];
    logic [N_TIMER-1:0] tpend;

    for (genvar k = 0; k < N_TIMER; k++) begin : g_cmp
        logic        cmp_wr;
        logic [31:0] cmp_q;
        logic        tp_q;

        assign cmp_wr = reg_hit(bus.wen, bus.addr, CP0_COMPARE)
                        && (bus.sel == 3'(k));

        // a Compare write beats a same-cycle match
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cmp_q <= '0;
                tp_q  <= 1'b0;
            end else if (cmp_wr) begin
                cmp_q <= bus.wdata;
                tp_q  <= 1'b0;
            end else if (count == cmp_q && cmp_q != '0) begin
                tp_q  <= 1'b1;
            end
        end

        assign cmp_val[k] = cmp_q;
        assign tpend[k]   = tp_q;
    end

    assign ti = |tpend;

    logic [N_EXT-1:0] es;

    for (genvar i = 0; i < N_EXT; i++) begin : g_sync
        int_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (ext_int[i]),
            .q   (es[i])
        );
    end

    always_comb begin
        hw_ip = '0;
        for (int i = 0; i < N_EXT; i++) hw_ip[i] = es[i];
        hw_ip[IP7_BIT] = hw_ip[IP7_BIT] | ti;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) int_req <= 1'b0;
        else     int_req <= status_ie & ~status_exl
                            & |({hw_ip, sw_ip} & status_im);
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.addr == CP0_COUNT) begin
            bus.rdata = count;
        end else if (bus.addr == CP0_COMPARE) begin
            for (int k = 0; k < N_TIMER; k++)
                if (bus.sel == 3'(k)) bus.rdata = cmp_val[k];
        end
    end
endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed + random bench for cp0_timer_intc against an arithmetic
// model: Count = base + edges/DIV, pending flags, delayed ext history.
module tb_cp0_timer_intc;
    localparam int DIV = 2;
    localparam int NT  = 2;
    localparam int NE  = 6;
    localparam int SS  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] ext_int;
    logic          status_ie, status_exl;
    logic [7:0]    status_im;
    logic [1:0]    sw_ip;
    logic [5:0]    hw_ip;
    logic          ti;
    logic [31:0]   count;
    logic          int_req;

    cp0_timer_intc_if bus ();

    cp0_timer_intc #(
        .COUNT_DIV   (DIV),
        .N_TIMER     (NT),
        .N_EXT       (NE),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_int    (ext_int),
        .bus        (bus.slave),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_im  (status_im),
        .sw_ip      (sw_ip),
        .hw_ip      (hw_ip),
        .ti         (ti),
        .count      (count),
        .int_req    (int_req)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned m_n;
    logic [31:0] m_base;
    logic [31:0] m_cmp [NT];
    bit [NT-1:0] m_tp;
    logic [5:0]  hist [$];
    logic        m_req;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_n / DIV);
    endfunction

    function automatic logic [5:0] m_hw();
        logic [5:0] h;
        h = hist[SS-1];
        h[5] = h[5] | (|m_tp);
        return h;
    endfunction

    function automatic logic [31:0] m_rd();
        if (bus.addr == 5'd9) return m_count();
        if (bus.addr == 5'd11 && bus.sel < 3'(NT)) return m_cmp[bus.sel];
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_base = '0;
        for (int k = 0; k < NT; k++) m_cmp[k] = '0;
        m_tp   = '0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_front(6'd0);
        m_req  = 1'b0;
    endtask

    task automatic check_all();
        chk("count",   count,        m_count());
        chk("hw_ip",   32'(hw_ip),   32'(m_hw()));
        chk("ti",      32'(ti),      32'(|m_tp));
        chk("int_req", 32'(int_req), 32'(m_req));
        chk("rdata",   bus.rdata,    m_rd());
    endtask

    task automatic cyc(input bit w, input logic [4:0] a,
                       input logic [2:0] s, input logic [31:0] d);
        logic [31:0] cb;
        logic [5:0]  hb;
        bus.wen = w; bus.addr = a; bus.sel = s; bus.wdata = d;
        @(posedge clk);
        cb = m_count();
        hb = m_hw();
        m_req = status_ie & ~status_exl & |({hb, sw_ip} & status_im);
        for (int k = 0; k < NT; k++) begin
            if (w && a == 5'd11 && s == 3'(k)) begin
                m_cmp[k] = d;
                m_tp[k]  = 1'b0;
            end else if (cb == m_cmp[k] && m_cmp[k] != 0) begin
                m_tp[k] = 1'b1;
            end
        end
        if (w && a == 5'd9) begin
            m_base = d;
            m_n    = 0;
        end else begin
            m_n++;
        end
        hist.push_front(ext_int);
        void'(hist.pop_back());
        #1;
        bus.wen = 1'b0;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ext_int = '0;
        status_ie = 1'b0; status_exl = 1'b0; status_im = '0; sw_ip = '0;
        bus.wen = 1'b0; bus.addr = 5'd9; bus.sel = '0; bus.wdata = '0;
        model_reset();
        #12;
        chk("rst_count", count, 32'd0);
        chk("rst_ti",    32'(ti), 32'd0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // prescaler / Count sequence and wrap
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 5'd9, 3'd0, 32'd0);
            chk("cnt_seq", count, 32'(i / 2));
        end
        cyc(1, 5'd9, 3'd0, 32'hFFFF_FFFE);
        chk("cnt_load", count, 32'hFFFF_FFFE);
        repeat (4) cyc(0, 5'd9, 3'd0, 32'd0);
        chk("cnt_wrap", count, 32'd0);

        // compare match
        status_ie = 1'b1; status_im = 8'h80;
        cyc(1, 5'd9, 3'd0, 32'd0);
        cyc(1, 5'd11, 3'd0, 32'd5);
        for (int i = 0; i < 40 && count !== 32'd5; i++)
            cyc(0, 5'd9, 3'd0, 32'd0);
        chk("reach5", count, 32'd5);
        chk("ti_pre", 32'(ti), 32'd0);
        cyc(0, 5'd9, 3'd0, 32'd0);
        chk("ti_rise", 32'(ti), 32'd1);
        chk("req_lag", 32'(int_req), 32'd0);
        cyc(0, 5'd9, 3'd0, 32'd0);
        chk("req_rise", 32'(int_req), 32'd1);
        cyc(1, 5'd11, 3'd0, 32'd1000);
        chk("ti_clear", 32'(ti), 32'd0);
        cyc(0, 5'd9, 3'd0, 32'd0);
        chk("req_clear", 32'(int_req), 32'd0);

        // write vs match collision
        cyc(1, 5'd9, 3'd0, 32'd20);
        cyc(1, 5'd11, 3'd0, 32'd25);
        for (int i = 0; i < 40 && count !== 32'd25; i++)
            cyc(0, 5'd9, 3'd0, 32'd0);
        chk("reach25", count, 32'd25);
        cyc(1, 5'd11, 3'd0, 32'd200);
        chk("collide_ti", 32'(ti), 32'd0);
        repeat (4) cyc(0, 5'd9, 3'd0, 32'd0);
        chk("collide_hold", 32'(ti), 32'd0);

        // multi-channel
        cyc(1, 5'd11, 3'd0, 32'd0);
        cyc(1, 5'd11, 3'd1, 32'd3);
        cyc(1, 5'd9, 3'd0, 32'd0);
        repeat (10) cyc(0, 5'd9, 3'd0, 32'd0);
        chk("ch1_ti", 32'(ti), 32'd1);
        cyc(0, 5'd11, 3'd1, 32'd0);
        chk("rd_cmp1", bus.rdata, 32'd3);
        cyc(0, 5'd11, 3'd0, 32'd0);
        chk("rd_cmp0", bus.rdata, 32'd0);
        cyc(1, 5'd11, 3'd1, 32'd0);
        chk("ch0_quiet", 32'(ti), 32'd0);
        cyc(1, 5'd11, 3'd2, 32'h55);
        cyc(0, 5'd11, 3'd2, 32'd0);
        chk("rd_sel2", bus.rdata, 32'd0);

        // external line latency with masked im[4]
        status_im = 8'hEF;
        ext_int = 6'b000100;
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) ext_int = '0;
            cyc(0, 5'd0, 3'd0, 32'd0);
            chk("ext_lat", 32'(hw_ip[2]), 32'(i >= 2 && i <= 5));
            chk("masked_req", 32'(int_req), 32'd0);
        end
        ext_int = 6'b000100; status_im = 8'hFF; status_exl = 1'b1;
        repeat (4) cyc(0, 5'd0, 3'd0, 32'd0);
        chk("exl_req", 32'(int_req), 32'd0);
        status_exl = 1'b0;
        cyc(0, 5'd0, 3'd0, 32'd0);
        chk("exl_drop", 32'(int_req), 32'd1);
        ext_int = '0;

        // compare just above the wrap point
        cyc(1, 5'd9, 3'd0, 32'hFFFF_FFFC);
        cyc(1, 5'd11, 3'd0, 32'd1);
        for (int i = 0; i < 30 && ti !== 1'b1; i++)
            cyc(0, 5'd9, 3'd0, 32'd0);
        chk("wrap_ti", 32'(ti), 32'd1);
        chk("wrap_cnt", count, 32'd1);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int r;
            ext_int    = 6'($urandom_range(0, 63));
            status_ie  = ($urandom_range(0, 3) != 0);
            status_exl = ($urandom_range(0, 3) == 0);
            status_im  = 8'($urandom_range(0, 255));
            sw_ip      = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            if (r == 0)
                cyc(1, 5'd9, 3'd0, ($urandom_range(0, 1) != 0)
                    ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                    : 32'($urandom));
            else if (r <= 2)
                cyc(1, 5'd11, 3'($urandom_range(0, 3)),
                    m_count() + 32'($urandom_range(0, 8)));
            else if (r == 3)
                cyc(1, 5'($urandom_range(12, 31)), 3'd0, 32'($urandom));
            else
                cyc(0, ($urandom_range(0, 1) != 0) ? 5'd9 : 5'd11,
                    3'($urandom_range(0, 3)), 32'd0);
        end

        // asynchronous reset mid-operation
        ext_int = '0; status_ie = 1'b1; status_exl = 1'b0;
        status_im = 8'h80; sw_ip = '0;
        cyc(1, 5'd11, 3'd1, 32'd0);
        cyc(1, 5'd9, 3'd0, 32'h1230);
        cyc(1, 5'd11, 3'd0, 32'h1234);
        for (int i = 0; i < 30 && ti !== 1'b1; i++)
            cyc(0, 5'd9, 3'd0, 32'd0);
        chk("pre_rst_ti",  32'(ti), 32'd1);
        chk("pre_rst_cnt", count, 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 32'd0);
        chk("arst_ti",    32'(ti), 32'd0);
        chk("arst_hw",    32'(hw_ip), 32'd0);
        chk("arst_req",   32'(int_req), 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 5'd9, 3'd0, 32'd0);
        chk("rel_cnt0", count, 32'd0);
        cyc(0, 5'd9, 3'd0, 32'd0);
        chk("rel_cnt1", count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
